// File: rtl/uart_pixel_loader.sv
// uart_pixel_loader: turns the UART receive byte stream into 48-bit pixel
// words (two RGB888 pixels) and writes them into the pixel RAM.
// Packet: SYNC, ADDR_H, ADDR_L, LEN_H, LEN_L, then 6*LEN data bytes.
// Optional macro UART_PIXEL_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module uart_pixel_loader #(
  parameter int unsigned ADDR_WIDTH     = 9,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_busy,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [47:0]           wr_data,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err_timeout,
  output logic                  err_checksum
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR_H, ADDR_L, LEN_H, LEN_L, DATA
`ifdef UART_PIXEL_LOADER_CHECKSUM_EN
    , CHK
`endif
  } state_t;

  state_t                  state_q, state_d;
  logic                    busy_q;
  logic [TMR_W-1:0]        tmr_q;
  logic [7:0]              hi_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [15:0]             words_q;
  logic [2:0]              bcnt_q;
  logic [39:0]             shift_q;
  logic [15:0]             hdr16;

  logic byte_stb, timeout_hit, acc_stb;
  logic last_byte, last_word, len_zero;
  logic wr_en_d, frame_done_d, err_timeout_d;

`ifdef UART_PIXEL_LOADER_CHECKSUM_EN
  logic [7:0] chk_q;
  logic       err_checksum_d;
`endif

  // Stage p0: byte strobe on the falling edge of rx_busy, timeout arbitration
  assign byte_stb    = busy_q & ~rx_busy;
  assign timeout_hit = (state_q != IDLE) && (tmr_q == TMR_LAST);
  assign acc_stb     = byte_stb & ~timeout_hit;
  assign hdr16       = {hi_q, rx_data};
  assign last_byte   = acc_stb && (state_q == DATA) && (bcnt_q == 3'd5);
  assign last_word   = last_byte && (words_q == 16'd1);
  assign len_zero    = acc_stb && (state_q == LEN_L) && (hdr16 == 16'd0);
  assign busy        = (state_q != IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a timeout overrides any byte in the same cycle
  always_comb begin
    state_d = state_q;
    if (timeout_hit) begin
      state_d = IDLE;
    end else if (acc_stb) begin
      case (state_q)
        IDLE:   if (rx_data == SYNC_BYTE) state_d = ADDR_H;
        ADDR_H: state_d = ADDR_L;
        ADDR_L: state_d = LEN_H;
        LEN_H:  state_d = LEN_L;
`ifdef UART_PIXEL_LOADER_CHECKSUM_EN
        LEN_L:  state_d = len_zero ? CHK : DATA;
        DATA:   if (last_word) state_d = CHK;
        CHK:    state_d = IDLE;
`else
        LEN_L:  state_d = len_zero ? IDLE : DATA;
        DATA:   if (last_word) state_d = IDLE;
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  // Output decode: next values of the one-cycle pulse outputs
  always_comb begin
    wr_en_d       = last_byte;
    err_timeout_d = timeout_hit;
`ifdef UART_PIXEL_LOADER_CHECKSUM_EN
    frame_done_d   = acc_stb && (state_q == CHK) && (rx_data == chk_q);
    err_checksum_d = acc_stb && (state_q == CHK) && (rx_data != chk_q);
`else
    frame_done_d   = last_word | len_zero;
`endif
  end

  // Stage p1: registered outputs, counters, timer and header fields
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= 1'b0;
      tmr_q       <= '0;
      hi_q        <= '0;
      addr_q      <= '0;
      words_q     <= '0;
      bcnt_q      <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      busy_q      <= rx_busy;
      tmr_q       <= (state_q == IDLE || byte_stb) ? '0 : tmr_q + 1'b1;
      wr_en       <= wr_en_d;
      frame_done  <= frame_done_d;
      err_timeout <= err_timeout_d;
      if (wr_en_d) begin
        wr_addr <= addr_q;
        wr_data <= {shift_q, rx_data};
      end
      if (acc_stb) begin
        case (state_q)
          ADDR_H, LEN_H: hi_q <= rx_data;
          ADDR_L:        addr_q <= hdr16[ADDR_WIDTH-1:0];
          LEN_L: begin
            words_q <= hdr16;
            bcnt_q  <= 3'd0;
          end
          DATA: begin
            if (bcnt_q == 3'd5) begin
              bcnt_q  <= 3'd0;
              addr_q  <= addr_q + 1'b1;
              words_q <= words_q - 16'd1;
            end else begin
              bcnt_q <= bcnt_q + 3'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Word assembly shift register, MSB byte first
  always_ff @(posedge clk) begin
    if (acc_stb && state_q == DATA) shift_q <= {shift_q[31:0], rx_data};
  end

`ifdef UART_PIXEL_LOADER_CHECKSUM_EN
  // Running XOR of every byte after SYNC, and the checksum error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_q        <= '0;
      err_checksum <= 1'b0;
    end else begin
      err_checksum <= err_checksum_d;
      if (acc_stb) begin
        if (state_q == IDLE)     chk_q <= '0;
        else if (state_q != CHK) chk_q <= chk_q ^ rx_data;
      end
    end
  end
`else
  assign err_checksum = 1'b0;
`endif

endmodule

// File: tb/tb_uart_pixel_loader.sv
// Scoreboard bench for uart_pixel_loader: packets are described as word lists,
// expected RAM writes and completion pulses are queued, a monitor checks them.
module tb_uart_pixel_loader;

  localparam int          AW      = 9;
  localparam logic [7:0]  SYNC    = 8'hA5;
  localparam int          TIMEOUT = 50;
`ifdef UART_PIXEL_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_busy;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [47:0]   wr_data;
  logic          busy;
  logic          frame_done;
  logic          err_timeout;
  logic          err_checksum;

  uart_pixel_loader #(
    .ADDR_WIDTH(AW),
    .SYNC_BYTE(SYNC),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_busy(rx_busy),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .busy(busy),
    .frame_done(frame_done),
    .err_timeout(err_timeout),
    .err_checksum(err_checksum)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [47:0]   data;
    logic          fd;
    logic          tmo;
    logic          ck;
  } ev_t;

  ev_t         exp_q[$];
  logic [47:0] words_m[16];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: any pulse output is an event that must match the queue head
  always @(negedge clk) begin
    ev_t e;
    if (!rst && (wr_en || frame_done || err_timeout || err_checksum)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {60'd0, wr_en, frame_done, err_timeout, err_checksum}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_en", 64'(wr_en), 64'(e.wr));
        if (e.wr) begin
          check("wr_addr", 64'(wr_addr), 64'(e.addr));
          check("wr_data", 64'(wr_data), 64'(e.data));
        end
        check("frame_done", 64'(frame_done), 64'(e.fd));
        check("err_timeout", 64'(err_timeout), 64'(e.tmo));
        check("err_checksum", 64'(err_checksum), 64'(e.ck));
        if (frame_done || err_timeout) check("busy_after_end", 64'(busy), 64'd0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_busy = 1'b1;
    rx_data = 8'($urandom);
    repeat ($urandom_range(1, 3)) @(posedge clk);
    #1;
    rx_data = b;
    rx_busy = 1'b0;
    repeat ($urandom_range(1, 3)) @(posedge clk);
    #1;
  endtask

  task automatic send_garbage(input int cnt);
    logic [7:0] g;
    for (int i = 0; i < cnt; i++) begin
      g = 8'($urandom_range(0, 255));
      if (g == SYNC) g = 8'h00;
      send_byte(g);
    end
  endtask

  // Send a packet whose payload is words_m[0..n-1]; only nbytes data bytes go out.
  task automatic send_packet(input logic [15:0] a16, input int n, input int nbytes,
                             input bit bad_chk, input bit aborted);
    ev_t        e;
    logic [7:0] cs, b;
    logic [15:0] t;
    logic [15:0] n16;
    bit         full;
    int         nw;
    n16  = 16'(n);
    full = (nbytes == 6 * n);
    nw   = nbytes / 6;
    if (!aborted) begin
      for (int i = 0; i < nw; i++) begin
        e      = '0;
        t      = a16 + 16'(i);
        e.wr   = 1'b1;
        e.addr = t[AW-1:0];
        e.data = words_m[i];
        e.fd   = (i == nw - 1) && full && !CHK_EN;
        exp_q.push_back(e);
      end
      e = '0;
      if (full) begin
        if (CHK_EN) begin
          e.fd = !bad_chk;
          e.ck = bad_chk;
          exp_q.push_back(e);
        end else if (n == 0) begin
          e.fd = 1'b1;
          exp_q.push_back(e);
        end
      end else begin
        e.tmo = 1'b1;
        exp_q.push_back(e);
      end
    end
    send_byte(SYNC);
    cs = a16[15:8] ^ a16[7:0] ^ n16[15:8] ^ n16[7:0];
    send_byte(a16[15:8]);
    send_byte(a16[7:0]);
    send_byte(n16[15:8]);
    send_byte(n16[7:0]);
    for (int k = 0; k < nbytes; k++) begin
      b  = words_m[k / 6][47 - 8 * (k % 6) -: 8];
      cs = cs ^ b;
      send_byte(b);
    end
    if (full && CHK_EN) send_byte(bad_chk ? (cs ^ 8'h10) : cs);
    if (!full && !aborted) begin
      repeat (TIMEOUT + 10) @(posedge clk);
      #1;
    end
  endtask

  task automatic rand_words(input int n);
    logic [63:0] r;
    for (int i = 0; i < n; i++) begin
      r = {$urandom, $urandom};
      words_m[i] = r[47:0];
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, pending=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nb, waited;
    rst     = 1'b1;
    rx_busy = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_err_timeout", 64'(err_timeout), 64'd0);
    check("rst_err_checksum", 64'(err_checksum), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Directed single-word packet
    words_m[0] = 48'h204F4C4C4548;
    send_packet(16'h0010, 1, 6, 1'b0, 1'b0);

    // Garbage then a two-word packet wrapping the address space
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    rand_words(2);
    send_packet(16'h01FF, 2, 12, 1'b0, 1'b0);

    // Truncated packet: 8 of 18 data bytes, then timeout; then a clean packet
    rand_words(3);
    send_packet(16'h0100, 3, 8, 1'b0, 1'b0);
    rand_words(1);
    send_packet(16'h0033, 1, 6, 1'b0, 1'b0);

    // Empty packet
    send_packet(16'h0000, 0, 0, 1'b0, 1'b0);

`ifdef UART_PIXEL_LOADER_CHECKSUM_EN
    // Corrupted checksum: writes land, err_checksum instead of frame_done
    rand_words(2);
    send_packet(16'h0080, 2, 12, 1'b1, 1'b0);
`endif

    // Reset in the middle of DATA after three bytes
    rand_words(2);
    send_packet(16'h0040, 2, 3, 1'b0, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_wr_en", 64'(wr_en), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rand_words(2);
    send_packet(16'h0041, 2, 12, 1'b0, 1'b0);

    // Randomized packets with garbage and occasional truncation
    for (int p = 0; p < 12; p++) begin
      send_garbage($urandom_range(0, 2));
      n = $urandom_range(0, 4);
      rand_words(n);
      nb = 6 * n;
      if (n > 0 && $urandom_range(0, 3) == 0) nb = $urandom_range(0, 6 * n - 1);
      send_packet(16'($urandom), n, nb, CHK_EN && ($urandom_range(0, 3) == 0), 1'b0);
    end

    // Drain: every queued expectation must have been seen
    waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      @(posedge clk);
      waited++;
    end
    repeat (5) @(posedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
